// File: rtl/fpu_round.sv
// Binary32 rounding stage: S1 decides the increment and applies it via 4-bit lookahead slices,
// S2 renormalizes, detects overflow and packs the result behind a valid/ready handshake.
module fpu_round (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic        i_in_sign,
   input  logic [7:0]  i_in_exp,
   input  logic [23:0] i_in_mant,
   input  logic [2:0]  i_in_grs,
   input  logic [1:0]  i_in_rmode,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_result,
   output logic        o_out_ovf,
   output logic        o_out_inexact
);

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   logic        r_s1_valid;
   logic        r_s1_sign;
   logic [7:0]  r_s1_exp;
   logic [24:0] r_s1_mi;
   logic        r_s1_inexact;
   logic        r_s1_special;
   logic [1:0]  r_s1_rmode;

   logic        r_out_valid;
   logic [31:0] r_out_result;
   logic        r_out_ovf;
   logic        r_out_inexact;

   logic        w_s2_en;
   logic        w_s1_en;
   logic        w_special;
   logic        w_any;
   logic        w_inc_mode;
   logic        w_inc;
   logic [6:0]  w_carry;
   logic [23:0] w_sum;

   assign w_s2_en    = !r_out_valid | i_out_ready;
   assign w_s1_en    = !r_s1_valid | w_s2_en;
   assign o_in_ready = w_s1_en;

   assign w_special = (i_in_exp == 8'hFF);
   assign w_any     = |i_in_grs;

   always_comb begin
      w_inc_mode = 1'b0;
      case (i_in_rmode)
         RM_RNE:  w_inc_mode = i_in_grs[2] & (i_in_grs[1] | i_in_grs[0] | i_in_mant[0]);
         RM_RTZ:  w_inc_mode = 1'b0;
         RM_RUP:  w_inc_mode = !i_in_sign & w_any;
         RM_RDN:  w_inc_mode = i_in_sign & w_any;
         default: w_inc_mode = 1'b0;
      endcase
   end

   assign w_inc      = w_inc_mode & !w_special;
   assign w_carry[0] = w_inc;

   // Each slice propagates its carry-in across the prefix of ones below each bit.
   for (genvar g = 0; g < 6; g++) begin : g_slice
      logic [3:0] w_a;
      logic       w_c;
      assign w_a = i_in_mant[4*g +: 4];
      assign w_c = w_carry[g];
      assign w_sum[4*g +: 4] = {w_a[3] ^ (w_c & w_a[0] & w_a[1] & w_a[2]),
                                w_a[2] ^ (w_c & w_a[0] & w_a[1]),
                                w_a[1] ^ (w_c & w_a[0]),
                                w_a[0] ^ w_c};
      assign w_carry[g+1] = w_c & (&w_a);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_sign    <= 1'b0;
         r_s1_exp     <= 8'h00;
         r_s1_mi      <= 25'h0;
         r_s1_inexact <= 1'b0;
         r_s1_special <= 1'b0;
         r_s1_rmode   <= 2'b00;
      end else if (w_s1_en) begin
         r_s1_valid <= i_in_valid;
         if (i_in_valid) begin
            r_s1_sign    <= i_in_sign;
            r_s1_exp     <= i_in_exp;
            r_s1_mi      <= {w_carry[6], w_sum};
            r_s1_inexact <= w_any & !w_special;
            r_s1_special <= w_special;
            r_s1_rmode   <= i_in_rmode;
         end
      end
   end

   logic [8:0]  w_exp9;
   logic [22:0] w_frac;
   logic        w_ovf;
   logic        w_to_inf;
   logic [31:0] w_result;
   logic        w_inexact;

   always_comb begin
      w_exp9 = {1'b0, r_s1_exp};
      w_frac = r_s1_mi[22:0];
      if (r_s1_mi[24]) begin
         w_exp9 = {1'b0, r_s1_exp} + 9'd1;
         w_frac = r_s1_mi[23:1];
      end else if (r_s1_exp == 8'h00 && r_s1_mi[23]) begin
         w_exp9 = 9'd1;
      end
   end

   always_comb begin
      w_to_inf = 1'b0;
      case (r_s1_rmode)
         RM_RNE:  w_to_inf = 1'b1;
         RM_RTZ:  w_to_inf = 1'b0;
         RM_RUP:  w_to_inf = !r_s1_sign;
         RM_RDN:  w_to_inf = r_s1_sign;
         default: w_to_inf = 1'b0;
      endcase
   end

   // Specials carry exponent 255 too, so they must be excluded from the overflow test.
   assign w_ovf = !r_s1_special && (w_exp9 >= 9'd255);

   always_comb begin
      w_result  = {r_s1_sign, w_exp9[7:0], w_frac};
      w_inexact = r_s1_inexact;
      if (r_s1_special) begin
         w_result  = {r_s1_sign, 8'hFF, r_s1_mi[22:0]};
         w_inexact = 1'b0;
      end else if (w_ovf) begin
         w_result  = w_to_inf ? {r_s1_sign, 8'hFF, 23'h0} : {r_s1_sign, 8'hFE, 23'h7FFFFF};
         w_inexact = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_result  <= 32'h0;
         r_out_ovf     <= 1'b0;
         r_out_inexact <= 1'b0;
      end else if (w_s2_en) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_result  <= w_result;
            r_out_ovf     <= w_ovf;
            r_out_inexact <= w_inexact;
         end
      end
   end

   assign o_out_valid   = r_out_valid;
   assign o_out_result  = r_out_result;
   assign o_out_ovf     = r_out_ovf;
   assign o_out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fpu_round.sv
// Bench for fpu_round: directed rounding/overflow/handshake cases plus randomized traffic
// scored against a packed-magnitude reference model.
module tb_fpu_round;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [23:0] in_mant;
   logic [2:0]  in_grs;
   logic [1:0]  in_rmode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_ovf;
   logic        out_inexact;

   fpu_round dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_sign     (in_sign),
      .i_in_exp      (in_exp),
      .i_in_mant     (in_mant),
      .i_in_grs      (in_grs),
      .i_in_rmode    (in_rmode),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_result  (out_result),
      .o_out_ovf     (out_ovf),
      .o_out_inexact (out_inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   int          n_checks = 0;
   int          n_errors = 0;
   logic [33:0] sb[$];
   logic [33:0] drv_exp;
   logic        acc;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Rounding viewed as an add on the packed {exp,frac} magnitude: a frac carry ripples
   // into the exponent, which covers both renormalization and denormal promotion.
   function automatic logic [33:0] ref_round(input logic s, input logic [7:0] e,
                                             input logic [23:0] m, input logic [2:0] grs,
                                             input logic [1:0] rm);
      logic        inc;
      logic        any;
      logic        to_inf;
      logic [31:0] mag;
      any = |grs;
      if (e == 8'hFF) return {2'b00, s, 8'hFF, m[22:0]};
      case (rm)
         2'b00:   inc = grs[2] & (grs[1] | grs[0] | m[0]);
         2'b01:   inc = 1'b0;
         2'b10:   inc = !s & any;
         default: inc = s & any;
      endcase
      mag = {1'b0, e, m[22:0]} + 32'(inc);
      if (mag >= 32'h7F800000) begin
         to_inf = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
         return {2'b11, s, (to_inf ? 31'h7F800000 : 31'h7F7FFFFF)};
      end
      return {1'b0, any, s, mag[30:0]};
   endfunction

   task automatic tick();
      logic [33:0] e;
      #1;
      acc = 1'b0;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out", 40'(out_valid), 40'h0);
         end else begin
            e = sb.pop_front();
            chk("result", {6'h0, out_ovf, out_inexact, out_result}, {6'h0, e});
         end
      end
      if (in_valid && in_ready) begin
         sb.push_back(drv_exp);
         acc = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic [2:0] grs, input logic [1:0] rm, input logic [33:0] expv);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      in_grs   = grs;
      in_rmode = rm;
      drv_exp  = expv;
   endtask

   task automatic send_hold(input string tag);
      int budget;
      budget = 0;
      acc = 1'b0;
      while (!acc && budget < 20) begin
         tick();
         budget++;
      end
      chk(tag, 40'(acc), 40'h1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int budget;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      budget    = 0;
      while (sb.size() != 0 && budget < 20) begin
         tick();
         budget++;
      end
      chk(tag, 40'(sb.size()), 40'h0);
   endtask

   task automatic rand_word();
      logic        s;
      logic [7:0]  e;
      logic [23:0] m;
      logic [2:0]  grs;
      logic [1:0]  rm;
      int          pick;
      pick = int'($urandom_range(0, 9));
      case (pick)
         0:       e = 8'h00;
         1:       e = 8'hFE;
         2:       e = 8'hFF;
         3:       e = 8'hFD;
         default: e = 8'($urandom_range(1, 254));
      endcase
      m = 24'($urandom);
      if ($urandom_range(0, 3) == 0) m[22:0] = '1;
      m[23] = (e != 8'h00);
      s   = 1'($urandom);
      grs = 3'($urandom);
      rm  = 2'($urandom);
      drive(s, e, m, grs, rm, ref_round(s, e, m, grs, rm));
   endtask

   logic [33:0] snap;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 8'h00;
      in_mant   = 24'h0;
      in_grs    = 3'b000;
      in_rmode  = 2'b00;
      out_ready = 1'b1;
      drv_exp   = 34'h0;
      acc       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_state", {3'b0, in_ready, out_valid, out_ovf, out_inexact, out_result},
          {3'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      rst_n = 1'b1;

      // Latency: accepted at one edge, visible after the second.
      drive(1'b0, 8'h80, 24'h800001, 3'b100, 2'b00, {2'b01, 32'h40000002});
      tick();
      in_valid = 1'b0;
      chk("latency_1", 40'(out_valid), 40'h0);
      tick();
      chk("latency_2", 40'(out_valid), 40'h1);
      drain("drain_latency");

      // Directed rounding cases, streamed back to back.
      drive(1'b0, 8'h80, 24'h800000, 3'b100, 2'b00, {2'b01, 32'h40000000}); tick();
      drive(1'b0, 8'h7F, 24'hFFFFFF, 3'b110, 2'b00, {2'b01, 32'h40000000}); tick();
      drive(1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 2'b00, {2'b11, 32'h7F800000}); tick();
      drive(1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 2'b01, {2'b01, 32'h7F7FFFFF}); tick();
      drive(1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 2'b10, {2'b11, 32'h7F800000}); tick();
      drive(1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 2'b11, {2'b01, 32'h7F7FFFFF}); tick();
      drive(1'b1, 8'hFE, 24'hFFFFFF, 3'b111, 2'b10, {2'b01, 32'hFF7FFFFF}); tick();
      drive(1'b1, 8'hFE, 24'hFFFFFF, 3'b111, 2'b11, {2'b11, 32'hFF800000}); tick();
      drive(1'b0, 8'h00, 24'h7FFFFF, 3'b100, 2'b00, {2'b01, 32'h00800000}); tick();
      drive(1'b0, 8'hFF, 24'h400000, 3'b111, 2'b00, {2'b00, 32'h7FC00000}); tick();
      drive(1'b1, 8'h85, 24'hA00003, 3'b000, 2'b10, {2'b00, 32'hC2A00003}); tick();
      drain("drain_directed");

      // Backpressure: two words fill the pipe, the third must wait.
      out_ready = 1'b0;
      rand_word(); tick();
      chk("bp_accept_a", 40'(acc), 40'h1);
      rand_word(); tick();
      chk("bp_accept_b", 40'(acc), 40'h1);
      rand_word();
      #1;
      chk("bp_in_ready_low", 40'(in_ready), 40'h0);
      snap = {out_ovf, out_inexact, out_result};
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", {4'h0, out_valid, in_ready, out_ovf, out_inexact, out_result},
             {4'h0, 1'b1, 1'b0, snap});
      end
      out_ready = 1'b1;
      send_hold("bp_accept_c");
      rand_word();
      send_hold("bp_accept_d");
      drain("drain_bp");

      // Reset with two words in flight.
      rand_word(); tick();
      rand_word(); tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      chk("rst_mid", {5'b0, in_ready, out_valid, out_result}, {5'b0, 1'b1, 1'b0, 32'h0});
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_no_stale", 40'(out_valid), 40'h0);
      end

      // Random traffic with random stalls on both sides.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) rand_word();
         else in_valid = 1'b0;
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain("drain_random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
